alarm_seq_ctrl: RTL and testbench

//  Event sequencer for the alarm clock FSM. Watches the FSM state, compares time-of-day with
//  the alarm setting, times the ring and snooze periods and decodes the user button.

---
 rtl/alarm_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_alarm_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_seq_ctrl.sv
// Event sequencer for the alarm clock FSM: detects the alarm time, times ring and
// snooze periods, decodes the snooze/off button and emits one-cycle strobes.
module alarm_seq_ctrl #(
  parameter  int RING_SEC       = 60,
  parameter  int SNOOZE_SEC     = 300,
  parameter  int LONG_PRESS_SEC = 2,
  parameter  int MAX_SNOOZES    = 3,
  localparam int SW             = $clog2(MAX_SNOOZES + 2)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sec_tick_i,
  input  logic [4:0]    cur_hour_i,
  input  logic [5:0]    cur_min_i,
  input  logic [4:0]    alarm_hour_i,
  input  logic [5:0]    alarm_min_i,
  input  logic [2:0]    fsm_state_i,
  input  logic          btn_i,
  output logic          alarm_start_o,
  output logic          alarm_timeout_o,
  output logic          alarm_force_snooze_o,
  output logic          alarm_snooze_timeout_o,
  output logic          alarm_off_o,
  output logic          buzzer_o,
  output logic [SW-1:0] snooze_cnt_o
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(SEC_MAX + 1);
  localparam int PW      = $clog2(LONG_PRESS_SEC + 1);

  localparam logic [CW-1:0] RING_LAST    = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_LAST  = CW'(SNOOZE_SEC - 1);
  localparam logic [PW-1:0] PRESS_LAST   = PW'(LONG_PRESS_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LIMIT = SW'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SET    = 2'b01,
    ST_ALARM  = 2'b10,
    ST_SNOOZE = 2'b11
  } state_t;

  state_t          state_q;
  state_t          cur_state;
  logic            match_q;
  logic            btn_q;
  logic            fired_q;
  logic            press_q;
  logic [CW-1:0]   sec_cnt_q;
  logic [PW-1:0]   press_cnt_q;

  logic entry, active, match, btn_rise;
  logic ring_end, snz_end, long_press, btn_release, short_press;
  logic at_limit, fired_now, start_cond;
  logic issue_start, issue_timeout, issue_force, issue_snz, issue_off, any_issue;

  always_comb begin
    // Illegal 1xx encodings collapse onto IDLE so they never look like an entry.
    cur_state   = fsm_state_i[2] ? ST_IDLE : state_t'(fsm_state_i[1:0]);
    entry       = (cur_state != state_q);
    active      = (cur_state == ST_ALARM) || (cur_state == ST_SNOOZE);
    match       = (cur_hour_i == alarm_hour_i) && (cur_min_i == alarm_min_i);
    btn_rise    = btn_i & ~btn_q;
    start_cond  = (cur_state == ST_SET) & match & ~match_q;

    ring_end    = ~entry & (cur_state == ST_ALARM)  & sec_tick_i & (sec_cnt_q == RING_LAST);
    snz_end     = ~entry & (cur_state == ST_SNOOZE) & sec_tick_i & (sec_cnt_q == SNOOZE_LAST);
    long_press  = press_q & active & btn_i & sec_tick_i & (press_cnt_q == PRESS_LAST);
    btn_release = press_q & active & ~btn_i;
    short_press = btn_release & (cur_state == ST_ALARM);

    at_limit    = (snooze_cnt_o >= SNOOZE_LIMIT);
    fired_now   = fired_q & ~entry;

    // Priority: off > timeout > force_snooze > snooze_timeout > start.
    issue_off     = ~fired_now & (long_press | ((ring_end | short_press) & at_limit));
    issue_timeout = ~fired_now & ~issue_off & ring_end;
    issue_force   = ~fired_now & ~issue_off & ~issue_timeout & short_press;
    issue_snz     = ~fired_now & ~issue_off & ~issue_timeout & ~issue_force & snz_end;
    issue_start   = ~fired_now & ~issue_off & ~issue_timeout & ~issue_force & ~issue_snz
                    & start_cond;
    any_issue     = issue_off | issue_timeout | issue_force | issue_snz | issue_start;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q                <= ST_IDLE;
      match_q                <= 1'b0;
      btn_q                  <= 1'b0;
      fired_q                <= 1'b0;
      press_q                <= 1'b0;
      sec_cnt_q              <= '0;
      press_cnt_q            <= '0;
      snooze_cnt_o           <= '0;
      alarm_start_o          <= 1'b0;
      alarm_timeout_o        <= 1'b0;
      alarm_force_snooze_o   <= 1'b0;
      alarm_snooze_timeout_o <= 1'b0;
      alarm_off_o            <= 1'b0;
      buzzer_o               <= 1'b0;
    end else begin
      state_q                <= cur_state;
      match_q                <= match;
      btn_q                  <= btn_i;
      fired_q                <= fired_now | any_issue;
      alarm_start_o          <= issue_start;
      alarm_timeout_o        <= issue_timeout;
      alarm_force_snooze_o   <= issue_force;
      alarm_snooze_timeout_o <= issue_snz;
      alarm_off_o            <= issue_off;
      buzzer_o               <= (cur_state == ST_ALARM);

      // The period counter wraps at its terminal count so it never overflows while fired.
      if (entry || !active) begin
        sec_cnt_q <= '0;
      end else if (sec_tick_i) begin
        if (ring_end || snz_end) begin
          sec_cnt_q <= '0;
        end else begin
          sec_cnt_q <= sec_cnt_q + CW'(1);
        end
      end

      if (!active) begin
        press_q <= 1'b0;
      end else if (btn_rise) begin
        press_q     <= 1'b1;
        press_cnt_q <= '0;
      end else if (long_press || btn_release) begin
        press_q <= 1'b0;
      end else if (press_q && btn_i && sec_tick_i) begin
        press_cnt_q <= press_cnt_q + PW'(1);
      end

      if (!active) begin
        snooze_cnt_o <= '0;
      end else if ((issue_timeout || issue_force) && (snooze_cnt_o < SNOOZE_LIMIT)) begin
        snooze_cnt_o <= snooze_cnt_o + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Randomized scoreboard bench for alarm_seq_ctrl; a closed-loop alarm FSM reacts to the
// reference model's strobes so complete ring/snooze/off sessions are exercised.
module tb_alarm_seq_ctrl;

  localparam int RING   = 3;
  localparam int SNOOZE = 4;
  localparam int LP     = 2;
  localparam int MAXS   = 1;
  localparam int NCYC   = 6000;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [2:0] fsm_state;
  logic       btn;
  logic       start_s, timeout_s, force_s, snz_s, off_s, buzzer;
  logic [1:0] snooze_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  // Reference model state, in terms of "what has happened since the state was entered".
  int m_prev_state, m_ticks, m_press_ticks, m_snoozes;
  bit m_prev_match, m_prev_btn, m_fired, m_press;

  int b_state, pending, rst_left, min_off;
  int n_start, n_timeout, n_force, n_snz, n_off;

  alarm_seq_ctrl #(
    .RING_SEC(RING), .SNOOZE_SEC(SNOOZE), .LONG_PRESS_SEC(LP), .MAX_SNOOZES(MAXS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sec_tick_i(sec_tick),
    .cur_hour_i(cur_hour), .cur_min_i(cur_min),
    .alarm_hour_i(alarm_hour), .alarm_min_i(alarm_min),
    .fsm_state_i(fsm_state), .btn_i(btn),
    .alarm_start_o(start_s), .alarm_timeout_o(timeout_s),
    .alarm_force_snooze_o(force_s), .alarm_snooze_timeout_o(snz_s),
    .alarm_off_o(off_s), .buzzer_o(buzzer), .snooze_cnt_o(snooze_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelStep(output logic [7:0] e);
    int s;
    bit entry, active, m, rise, ring_end, snz_end, lng, rel, shrt, lim;
    bit o_start, o_to, o_fs, o_snz, o_off;
    o_start = 0; o_to = 0; o_fs = 0; o_snz = 0; o_off = 0;
    if (rst) begin
      m_prev_state = 0; m_ticks = 0; m_press_ticks = 0; m_snoozes = 0;
      m_prev_match = 0; m_prev_btn = 0; m_fired = 0; m_press = 0;
      e = 8'h00;
      return;
    end
    s      = (fsm_state >= 3'd4) ? 0 : int'(fsm_state);
    entry  = (s != m_prev_state);
    active = (s == 2) || (s == 3);
    m      = (cur_hour == alarm_hour) && (cur_min == alarm_min);
    rise   = btn && !m_prev_btn;

    if (entry) begin
      m_ticks = 0;
      m_fired = 0;
    end else if (active && sec_tick) begin
      m_ticks++;
    end
    ring_end = !entry && s == 2 && sec_tick && (m_ticks % RING == 0);
    snz_end  = !entry && s == 3 && sec_tick && (m_ticks % SNOOZE == 0);

    lng = active && m_press && btn && sec_tick && (m_press_ticks + 1 == LP);
    rel = active && m_press && !btn;
    if (!active) m_press = 0;
    else if (rise) begin
      m_press = 1;
      m_press_ticks = 0;
    end else if (lng || rel) m_press = 0;
    else if (m_press && btn && sec_tick) m_press_ticks++;

    shrt = rel && s == 2;
    lim  = (m_snoozes >= MAXS);
    if (!m_fired) begin
      if (lng || ((ring_end || shrt) && lim)) o_off = 1;
      else if (ring_end)                      o_to = 1;
      else if (shrt)                          o_fs = 1;
      else if (snz_end)                       o_snz = 1;
      else if (s == 1 && m && !m_prev_match)  o_start = 1;
    end
    if (o_start || o_to || o_fs || o_snz || o_off) m_fired = 1;

    if (!active) m_snoozes = 0;
    else if ((o_to || o_fs) && m_snoozes < MAXS) m_snoozes++;

    m_prev_state = s;
    m_prev_match = m;
    m_prev_btn   = btn;
    e = {o_start, o_to, o_fs, o_snz, o_off, (s == 2), 2'(m_snoozes)};
  endtask

  task automatic applyStimulus(input int cyc);
    logic [7:0] e;
    int nxt;
    if (cyc < 3) rst = 1'b1;
    else if (rst_left > 0) begin
      rst = 1'b1;
      rst_left--;
    end else if (cyc > 20 && $urandom_range(399) == 0) begin
      rst = 1'b1;
      rst_left = int'($urandom_range(1));
    end else rst = 1'b0;

    sec_tick = ($urandom_range(2) == 0);
    if (!btn) btn = ($urandom_range(9) == 0);
    else      btn = ($urandom_range(4) != 0);

    if ($urandom_range(5) == 0) begin
      min_off  = (min_off + 1) % 6;
      cur_hour = ($urandom_range(9) == 0) ? 5'd8 : 5'd7;
    end
    cur_min = 6'(27 + min_off);
    if ($urandom_range(499) == 0) alarm_min = 6'(29 + $urandom_range(2));

    // The bench FSM follows the expected strobes, sometimes one cycle late.
    if (pending >= 0) begin
      b_state = pending;
      pending = -1;
    end else if (last_exp[7:3] != 5'b0) begin
      if (last_exp[3])                    nxt = 0;
      else if (last_exp[6] | last_exp[5]) nxt = 3;
      else                                nxt = 2;
      if ($urandom_range(3) == 0) pending = nxt;
      else                        b_state = nxt;
    end else if ($urandom_range(149) == 0) b_state = int'($urandom_range(7));
    else if (b_state == 0 && $urandom_range(9) == 0) b_state = 1;
    else if (b_state >= 4 && $urandom_range(4) == 0) b_state = 0;
    fsm_state = 3'(b_state);

    modelStep(e);
    exp_q.push_back(e);
    last_exp = e;
    n_start   += int'(e[7]);
    n_timeout += int'(e[6]);
    n_force   += int'(e[5]);
    n_snz     += int'(e[4]);
    n_off     += int'(e[3]);
  endtask

  task automatic checkOutput(input logic [7:0] expv, input logic [7:0] actv);
    vectors++;
    if (actv !== expv) begin
      miscompares++;
      $display("[TB] FAIL outputs t=%0t actual=%b expected=%b (start,timeout,force,snz,off,buzz,cnt)",
               $time, actv, expv);
    end
  endtask

  // Monitor: one registered output vector per clock, checked 1 time unit after the edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e, {start_s, timeout_s, force_s, snz_s, off_s, buzzer, snooze_cnt});
      end
    end
  end

  initial begin
    rst = 1'b1; sec_tick = 1'b0; btn = 1'b0; fsm_state = 3'd0;
    cur_hour = 5'd7; cur_min = 6'd27; alarm_hour = 5'd7; alarm_min = 6'd30;
    b_state = 0; pending = -1; rst_left = 0; min_off = 0; last_exp = 8'h00;
    n_start = 0; n_timeout = 0; n_force = 0; n_snz = 0; n_off = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      applyStimulus(c);
    end
    @(posedge clk);
    #3;
    $display("[TB] expected strobes: start=%0d timeout=%0d force=%0d snz=%0d off=%0d",
             n_start, n_timeout, n_force, n_snz, n_off);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
